seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan_pkg.sv | 35 +++
 rtl/hex_to_seg7.sv | 13 +
 rtl/seg_scan.sv | 137 +++++++++++++
 tb/tb_seg_scan.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared seven-segment display definitions.
// Segment vectors are {g,f,e,d,c,b,a}, active-low, so a 0 bit lights a segment.
// Other display blocks import these constants so every block draws the same glyphs.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StShow
    } scan_state_e;

    // All segments off.
    localparam logic [6:0] SegDark = 7'h7F;

    // Glyphs 0..F, indexed by nibble value (element 0 is the rightmost entry).
    localparam logic [15:0][6:0] SegHex = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder.
//   hex : 4-bit value to display
//   seg : active-low cathode pattern {g,f,e,d,c,b,a}
module hex_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SegHex[hex];

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment display scanner.
// Steps through DIGITS digits, one per rising transition of scan_clk, and inserts
// BLANK_CYCLES cycles with every anode off after each switch so that the previous
// digit's pattern never ghosts onto the next one. All outputs are registered.
//   clk        : clock, all state changes on its rising edge
//   rst_n      : synchronous active-low reset
//   en         : scan enable; low forces the display dark and holds digit_idx
//   scan_clk   : divided scan rate, synchronous to clk
//   data       : one hex nibble per digit, digit k at data[4k+3:4k]
//   dp         : decimal point request per digit, 1 = lit
//   digit_mask : per-digit enable, 1 = digit may light
//   an         : anodes, active-low, at most one low
//   seg        : cathodes {g,f,e,d,c,b,a}, active-low
//   dp_n       : decimal point cathode, active-low
//   digit_idx  : currently selected digit
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      scan_clk,
    input  logic [4*DIGITS-1:0]       data,
    input  logic [DIGITS-1:0]         dp,
    input  logic [DIGITS-1:0]         digit_mask,
    output logic [DIGITS-1:0]         an,
    output logic [6:0]                seg,
    output logic                      dp_n,
    output logic [$clog2(DIGITS)-1:0] digit_idx
);

    localparam int unsigned     IdxW      = $clog2(DIGITS);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(DIGITS - 1);
    localparam logic [7:0]      BlankLoad = 8'(BLANK_CYCLES - 1);

    scan_state_e       state_q, state_d;
    logic [7:0]        blank_cnt_q, blank_cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              scan_prev_q;
    logic              tick;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_n_q, dp_n_d;
    logic [3:0]        nibble;
    logic [6:0]        seg_dec;
    logic [DIGITS-1:0] an_sel;

    assign tick   = scan_clk & ~scan_prev_q;
    assign nibble = data[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .hex (nibble),
        .seg (seg_dec)
    );

    // Anode pattern for the selected digit; a masked digit keeps its slot but stays dark.
    always_comb begin
        an_sel = '1;
        if (digit_mask[idx_q]) begin
            an_sel[idx_q] = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        idx_d       = idx_q;
        an_d        = '1;
        seg_d       = SegDark;
        dp_n_d      = 1'b1;

        // en has priority over any tick, so a coincident tick never advances the digit.
        if (!en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d     = StBlank;
                    blank_cnt_d = BlankLoad;
                end
                StBlank: begin
                    // Ticks are ignored here; the divider keeps them well apart.
                    if (blank_cnt_q == 8'd0) begin
                        // Latch the glyph once on entry so mid-slot data edits stay hidden.
                        state_d = StShow;
                        an_d    = an_sel;
                        seg_d   = seg_dec;
                        dp_n_d  = ~dp[idx_q];
                    end else begin
                        blank_cnt_d = blank_cnt_q - 8'd1;
                    end
                end
                StShow: begin
                    if (tick) begin
                        state_d     = StBlank;
                        blank_cnt_d = BlankLoad;
                        idx_d       = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                    end else begin
                        an_d   = an_sel;
                        seg_d  = seg_q;
                        dp_n_d = dp_n_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            blank_cnt_q <= 8'd0;
            idx_q       <= '0;
            scan_prev_q <= 1'b0;
            an_q        <= '1;
            seg_q       <= SegDark;
            dp_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            idx_q       <= idx_d;
            scan_prev_q <= scan_clk;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_n_q      <= dp_n_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp_n      = dp_n_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan (DIGITS=8, BLANK_CYCLES=4, scan_clk period 40 clk).
// Expected samples are queued with a due cycle when scan_clk rises and are
// compared on the falling clk edge they fall due.
module tb_seg_scan;

    localparam int Period = 40;

    localparam logic [6:0] SegRef [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        int         due;
        string      tag;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic [2:0] idx;
        bit         chk_seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        scan_clk;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  digit_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic [2:0]  digit_idx;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          phase    = 0;
    logic [2:0]  exp_idx  = 3'd0;
    bit          sb_on    = 1'b1;
    bit          drop_pending = 1'b0;

    seg_scan #(
        .DIGITS       (8),
        .BLANK_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .scan_clk   (scan_clk),
        .data       (data),
        .dp         (dp),
        .digit_mask (digit_mask),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .digit_idx  (digit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Dark for the 4 blank cycles, then the digit lit at c+5 and still lit mid-slot.
    task automatic push_digit(input int c, input logic [2:0] idx);
        exp_t       e;
        logic [3:0] nib;
        logic [7:0] an_exp;
        nib    = data[4*idx +: 4];
        an_exp = 8'hFF;
        if (digit_mask[idx]) an_exp[idx] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            e = '{due: c + k, tag: $sformatf("blank%0d_d%0d", k, idx), an: 8'hFF,
                  seg: 7'h7F, dp_n: 1'b1, idx: idx, chk_seg: 1'b0};
            sb.push_back(e);
        end
        e = '{due: c + 5, tag: $sformatf("lit_d%0d", idx), an: an_exp, seg: SegRef[nib],
              dp_n: ~dp[idx], idx: idx, chk_seg: 1'b1};
        sb.push_back(e);
        e.due = c + 15;
        e.tag = $sformatf("hold_d%0d", idx);
        sb.push_back(e);
    endtask

    task automatic push_idle(input int c, input logic [2:0] idx);
        exp_t e;
        for (int k = 1; k <= 3; k++) begin
            e = '{due: c + k, tag: $sformatf("endrop%0d", k), an: 8'hFF, seg: 7'h7F,
                  dp_n: 1'b1, idx: idx, chk_seg: 1'b1};
            sb.push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({e.tag, "_an"}, 32'(an), 32'(e.an));
            check({e.tag, "_idx"}, 32'(digit_idx), 32'(e.idx));
            if (e.chk_seg) begin
                check({e.tag, "_seg"}, 32'(seg), 32'(e.seg));
                check({e.tag, "_dpn"}, 32'(dp_n), 32'(e.dp_n));
            end
        end
        phase    = (phase + 1) % Period;
        scan_clk = (phase >= Period / 2);
        if (phase == Period / 2 && en && sb_on) begin
            if (drop_pending && exp_idx == 3'd3) begin
                en           = 1'b0;
                drop_pending = 1'b0;
                push_idle(cyc, exp_idx);
            end else begin
                exp_idx = exp_idx + 3'd1;
                push_digit(cyc, exp_idx);
            end
        end
    endtask

    task automatic run_to(input int idx, input int ph);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(exp_idx == 3'(idx) && phase == ph) && n < 2000);
        check($sformatf("reach_d%0d_p%0d", idx, ph), 32'(n < 2000), 32'd1);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        en         = 1'b1;
        scan_clk   = 1'b0;
        data       = 32'h89ABCDEF;
        dp         = 8'b1001_0110;
        digit_mask = 8'hFF;

        // Reset holds everything dark even with en high and scan_clk toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc++;
            check("rst_an", 32'(an), 32'hFF);
            check("rst_seg", 32'(seg), 32'h7F);
            check("rst_dpn", 32'(dp_n), 32'd1);
            check("rst_idx", 32'(digit_idx), 32'd0);
            scan_clk = ~scan_clk;
        end
        rst_n    = 1'b1;
        scan_clk = 1'b0;
        phase    = 0;
        exp_idx  = 3'd0;
        push_digit(cyc, 3'd0);

        // Full rotation F,E,d,C,b,A,9,8 then wrap to digit 0.
        run_to(0, 30);

        // Digit 1 masked for one rotation.
        digit_mask = 8'b1111_1101;
        run_to(7, 30);
        data[3:0] = 4'h0;
        run_to(0, 28);
        // Digit 0 is latched as 0; this edit must only show on the next visit.
        data[3:0]  = 4'h8;
        digit_mask = 8'hFF;
        run_to(1, 30);
        run_to(0, 36);

        // en falls on the same cycle as the tick leaving digit 3.
        drop_pending = 1'b1;
        n = 0;
        while (drop_pending && n < 2000) begin
            step();
            n++;
        end
        check("drop_seen", 32'(drop_pending), 32'd0);
        repeat (5) step();
        en = 1'b1;
        push_digit(cyc, exp_idx);
        run_to(5, 36);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Random traffic: never more than one anode low.
        sb_on = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 49) == 0) en = ~en;
            data       = $urandom();
            digit_mask = 8'($urandom_range(0, 255));
            step();
            check("onehot", 32'($countones(~an) <= 1), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
